// File: rtl/pc_step_pkg.sv
// Shared definitions for the pc_step_counter slice: datapath width, FSM encoding
// and default reset / terminal-count values.
package pc_step_pkg;

  localparam int PC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam logic [PC_W-1:0] RESET_VAL_DEF = 16'h0000;
  localparam logic [PC_W-1:0] TC_VAL_DEF    = 16'hFFFF;

endpackage

// File: rtl/pc_inc17.sv
// Combinational +1 incrementer: 16-bit input, 17-bit result (bit 16 = carry-out),
// built as a ripple chain of NAND-only half-adder cells.
module pc_inc17
  import pc_step_pkg::*;
(
  input  logic [PC_W-1:0] a_i,
  output logic [PC_W:0]   sum_o
);

  // carry[0] is the constant +1 injected into bit 0.
  logic [PC_W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < PC_W; i++) begin : g_bit
    logic n_ab;
    logic n_a;
    logic n_b;

    assign n_ab         = ~(a_i[i] & carry[i]);
    assign n_a          = ~(a_i[i] & n_ab);
    assign n_b          = ~(carry[i] & n_ab);
    assign sum_o[i]     = ~(n_a & n_b);
    assign carry[i+1]   = ~(n_ab & n_ab);
  end

  assign sum_o[PC_W] = carry[PC_W];

endmodule

// File: rtl/pc_step_counter.sv
// Registered program-counter / address-sequencer step counter with run control,
// parallel load, terminal-count and sticky overflow. Define PC_STEP_SATURATE_EN to saturate at 16'hFFFF instead of wrapping.
module pc_step_counter
  import pc_step_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VAL = RESET_VAL_DEF,
  parameter logic [PC_W-1:0] TC_VAL    = TC_VAL_DEF,
  parameter bit              AUTO_STOP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic            step,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] count,
  output logic            busy,
  output logic            tc,
  output logic            ovf,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            tc_q, busy_q, halted_q;
  logic [PC_W:0]   sum;

  pc_inc17 u_inc (
    .a_i   (count_q),
    .sum_o (sum)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (stop)       state_d = ST_IDLE;
        else if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // load outranks stop and step; start is ignored while running.
        if (!load) begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (step) begin
            if (sum[PC_W]) begin
              ovf_d = 1'b1;
`ifdef PC_STEP_SATURATE_EN
              count_d = count_q;
`else
              count_d = sum[PC_W-1:0];
`endif
              if (AUTO_STOP) state_d = ST_HALT;
            end else begin
              count_d = sum[PC_W-1:0];
            end
          end
        end
      end
      ST_HALT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      count_d = load_val;
      ovf_d   = 1'b0;
    end
  end

  // Flags are registered from next-state values so they line up with count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= RESET_VAL;
      ovf_q    <= 1'b0;
      tc_q     <= (RESET_VAL == TC_VAL);
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      tc_q     <= (count_d == TC_VAL);
      busy_q   <= (state_d == ST_RUN);
      halted_q <= (state_d == ST_HALT);
    end
  end

  assign count  = count_q;
  assign busy   = busy_q;
  assign tc     = tc_q;
  assign ovf    = ovf_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_pc_step_counter.sv
// Self-checking bench for pc_step_counter: directed scenarios followed by random
// traffic, compared against an arithmetic reference model.
module tb_pc_step_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, step, load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        busy, tc, ovf, halted;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = halted.
  int          m_mode;
  int unsigned m_count;
  bit          m_ovf;

  pc_step_counter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .step     (step),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .busy     (busy),
    .tc       (tc),
    .ovf      (ovf),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},  count,           m_count[15:0]);
    chk({tag, ".busy"},   {15'd0, busy},   {15'd0, m_mode == 1});
    chk({tag, ".halted"}, {15'd0, halted}, {15'd0, m_mode == 2});
    chk({tag, ".tc"},     {15'd0, tc},     {15'd0, m_count == 32'hFFFF});
    chk({tag, ".ovf"},    {15'd0, ovf},    {15'd0, m_ovf});
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_count = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_advance(input bit st, input bit sp, input bit stp,
                               input bit ld, input logic [15:0] lv);
    case (m_mode)
      0: if (sp) m_mode = 0; else if (st) m_mode = 1;
      1: begin
        if (!ld && sp) begin
          m_mode = 0;
        end else if (!ld && stp) begin
          if (m_count == 32'hFFFF) begin
            m_ovf = 1'b1;
`ifdef PC_STEP_SATURATE_EN
            m_count = 32'hFFFF;
`else
            m_count = 0;
`endif
            m_mode = 2;
          end else begin
            m_count = m_count + 1;
          end
        end
      end
      default: begin
        if (sp) m_mode = 0;
        else if (st) begin m_mode = 1; m_ovf = 1'b0; end
      end
    endcase
    if (ld) begin
      m_count = 32'(lv);
      m_ovf   = 1'b0;
    end
  endtask

  task automatic cyc(input bit st, input bit sp, input bit stp, input bit ld,
                     input logic [15:0] lv, input string tag);
    start = st; stop = sp; step = stp; load = ld; load_val = lv;
    model_advance(st, sp, stp, ld, lv);
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; step = 1'b0; load = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [15:0] sweep_in  [4];
    logic [15:0] sweep_out [4];
    sweep_in  = '{16'h07FF, 16'h0FFF, 16'h00FF, 16'h7FFF};
    sweep_out = '{16'h0800, 16'h1000, 16'h0100, 16'h8000};

    start = 1'b0; stop = 1'b0; step = 1'b0; load = 1'b0; load_val = 16'h0000;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    cyc(1, 0, 0, 0, 16'h0, "start");
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 16'h0, "step5");
    chk("five_steps_count", count, 16'h0005);

    cyc(0, 0, 0, 1, 16'hFFFE, "load_fffe");
    cyc(0, 0, 1, 0, 16'h0, "to_ffff");
    chk("tc_at_ffff", {15'd0, tc}, 16'h0001);
    cyc(0, 0, 1, 0, 16'h0, "overflow");
`ifdef PC_STEP_SATURATE_EN
    chk("ovf_count", count, 16'hFFFF);
`else
    chk("ovf_count", count, 16'h0000);
`endif
    chk("ovf_halted", {15'd0, halted}, 16'h0001);

    cyc(0, 0, 1, 0, 16'h0, "step_in_halt");
    cyc(1, 0, 0, 0, 16'h0, "restart");
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, sweep_in[i], "sweep_load");
      cyc(0, 0, 1, 0, 16'h0, "sweep_step");
      chk("sweep_result", count, sweep_out[i]);
    end

    cyc(0, 1, 0, 0, 16'h0, "stop");
    cyc(1, 1, 0, 0, 16'h0, "start_stop_idle");
    chk("start_stop_busy", {15'd0, busy}, 16'h0000);
    cyc(0, 0, 1, 0, 16'h0, "step_in_idle");
    cyc(1, 0, 0, 0, 16'h0, "start2");
    cyc(0, 0, 1, 1, 16'h1234, "load_step");
    chk("load_beats_step", count, 16'h1234);
    cyc(0, 1, 1, 0, 16'h0, "stop_step");
    cyc(1, 0, 0, 0, 16'h0, "start3");

    cyc(0, 0, 0, 1, 16'h009F, "load_9f");
    cyc(0, 0, 1, 0, 16'h0, "to_a0");
    chk("pre_reset_count", count, 16'h00A0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("held_reset");

    for (int i = 0; i < 600; i++) begin
      int          r;
      int          sel;
      bit          st, sp, stp, ld;
      logic [15:0] lv;
      r   = int'($urandom_range(0, 99));
      st  = 1'b0; sp = 1'b0; ld = 1'b0;
      stp = ($urandom_range(0, 99) < 70);
      lv  = 16'h0000;
      if (r < 8) begin
        ld  = 1'b1;
        sel = int'($urandom_range(0, 3));
        lv  = (sel == 0) ? 16'hFFFE : (sel == 1) ? 16'hFFFD : 16'($urandom);
      end else if (r < 20) begin
        st = 1'b1;
      end else if (r < 25) begin
        sp = 1'b1;
      end else if (r < 27) begin
        st = 1'b1; sp = 1'b1;
      end
      cyc(st, sp, stp, ld, lv, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
